// File: rtl/button_event_queue.sv
// Four-button capture unit: synchronise, debounce, detect presses and queue event codes for a polled read.
// Optional BUTTON_RELEASE_EVENTS_EN also queues release events (codes 5..8) and widens the code field to 4 bits.
module button_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        red_button,
    input  logic        blue_button,
    input  logic        green_button,
    input  logic        yellow_button,
    input  logic        poll,
    output logic [31:0] button_out,
    output logic [3:0]  pressed
);

`ifdef BUTTON_RELEASE_EVENTS_EN
    localparam int NSRC = 8;
    localparam int CW   = 4;
`else
    localparam int NSRC = 4;
    localparam int CW   = 3;
`endif
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [3:0] raw;
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] rise_evt;
`ifdef BUTTON_RELEASE_EVENTS_EN
    logic [3:0] fall_evt;
`endif
    logic [NSRC-1:0] src_set;

    assign raw = {yellow_button, green_button, blue_button, red_button};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-button debounce; an event is flagged on the same edge the stable level flips.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;
            logic             flip;

            assign flip         = (sync2_reg[gi] != stable_reg) && (cnt_reg == CNT_MAX);
            assign rise_evt[gi] = flip & ~stable_reg;
`ifdef BUTTON_RELEASE_EVENTS_EN
            assign fall_evt[gi] = flip & stable_reg;
`endif
            assign pressed[gi]  = stable_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_MAX) begin
                    cnt_reg    <= '0;
                    stable_reg <= ~stable_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

`ifdef BUTTON_RELEASE_EVENTS_EN
    assign src_set = {fall_evt, rise_evt};
`else
    assign src_set = rise_evt;
`endif

    logic [NSRC-1:0] pending_reg;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] grant;
    logic [CW-1:0]   push_code;
    logic [CW-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic             poll_prev_reg;
    logic [CW-1:0]    rd_code_reg;
    logic             rd_ovf_reg;
    logic [CW-1:0]    head_code;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;

    // Lowest index wins: presses red..yellow, then releases red..yellow.
    always_comb begin
        grant     = '0;
        push_code = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                push_code = CW'(i + 1);
            end
        end
    end

    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign push_req     = |pending_reg;
    assign pop          = poll & ~poll_prev_reg & ~empty;
    // A pop in the same cycle frees a slot, so a full queue still accepts the push.
    assign push         = push_req & (~full | pop);
    assign pending_next = (pending_reg & ~grant) | src_set;
    assign head_code    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_code;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            poll_prev_reg <= 1'b0;
            rd_code_reg   <= '0;
            rd_ovf_reg    <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            poll_prev_reg <= poll;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            if (pop) begin
                overflow_reg <= 1'b0;
            end else if (push_req && !push) begin
                overflow_reg <= 1'b1;
            end
            // Read word is frozen while the processor is addressing the port.
            if (!poll) begin
                rd_code_reg <= head_code;
                rd_ovf_reg  <= overflow_reg;
            end
        end
    end

    always_comb begin
        button_out          = '0;
        button_out[CW-1:0]  = rd_code_reg;
        button_out[8]       = rd_ovf_reg;
    end

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Capture unit between the four raw Simon buttons and the processor's memory-mapped button poll (load from address 7). Per button: synchronise and debounce, detect presses, queue them in a small FIFO in arrival order. On each poll, return the oldest event and pop it, so a press made while software is busy (LED flash, audio, servo move) is never lost.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles before a level change is accepted (10 ms at 50 MHz); legal range ≥2.
- `FIFO_DEPTH`, default 4: event slots; power of two, ≥2.
- `clock` in 1: system clock (50 MHz domain).
- `reset` in 1: asynchronous, active-low; clears all state.
- `red_button`, `blue_button`, `green_button`, `yellow_button` in 1 each: raw asynchronous inputs, active-high.
- `poll` in 1: high while the processor addresses the button port; may stay high several cycles.
- `button_out` out 32: read word; `[2:0]` event code, `[8]` overflow, all other bits 0.
- `pressed` out 4: debounced levels `{yellow, green, blue, red}`.

## Operation
- **Synchroniser:** two flops per button.
- **Debounce:** per button, one counter and one stable level.
  - Synced input equal to stable level: counter cleared.
  - Otherwise: counter increments.
  - Counter reaches `DEBOUNCE_CYCLES-1`: stable level flips and counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` produces no change.
- **Edge detect:** a 0→1 stable transition sets that button's `pending` bit.
- **Push arbiter:** each cycle, the lowest-index pending bit (red > blue > green > yellow) is pushed and cleared.
  - If the FIFO is full, the event is discarded, its pending bit is still cleared, and sticky `overflow` is set.
  - Simultaneous presses therefore enter the queue on consecutive cycles.
- **Event codes:** 1 = red, 2 = blue, 3 = green, 4 = yellow, 0 = queue empty.
- **Read register:**
  - Every cycle with `poll`=0 it loads {overflow, head code, or 0 if empty}.
  - While `poll`=1 it holds, so the word is stable for the whole access.
- **Pop:** on a poll rising edge (`poll`=1, previous `poll`=0), if the FIFO is non-empty, pop the head and clear `overflow`. Exactly one pop per poll assertion, regardless of its length.
- **Push and pop in the same cycle:** both occur and the count is unchanged. When full, this push succeeds (the pop frees the slot first).
- **Empty queue:** a poll performs no pop and returns 0.
- **Pointers:** read and write pointers are `log2(FIFO_DEPTH)` bits and wrap modulo depth. Count is one bit wider.

## Timing
- **Reset** (asynchronous, `reset`=0):
  - `button_out`=0, `pressed`=0.
  - FIFO empty, `overflow`=0, pending=0, counters=0, stable levels=0.
- **Reset released with a button held:** the button debounces to 1 and generates one press event.
- **Reset asserted mid-operation:** all queued and pending events are lost; no partial state survives.
- **Latency:** counting from the first clock edge that samples a new raw level, `pressed` changes after 2 + `DEBOUNCE_CYCLES` edges. `button_out` shows the code (queue empty, `poll` low) after `DEBOUNCE_CYCLES` + 4 edges (pending +1, push +1, read register +1).
- **Poll:** `button_out` is valid in the first cycle `poll` is high. The pop is visible from the cycle after `poll` falls.
- **Throughput:** one push and one pop per cycle maximum.

## Configuration
- `BUTTON_RELEASE_EVENTS_EN`
  - **Defined:** 1→0 stable transitions also set pending bits and enqueue release codes 5 = red, 6 = blue, 7 = green, 8 = yellow. Code field widens to `[3:0]`. Priority across the eight sources is presses (red→yellow), then releases (red→yellow).
  - **Undefined:** releases are ignored, code field is `[2:0]`, and bit 3 is 0.

## Test plan
Sim uses `DEBOUNCE_CYCLES`=4 and `FIFO_DEPTH`=4.
- **Single press:** raise `green_button` and hold 20 cycles → `pressed`=4'b0100 after 6 edges. With `poll` low, `button_out`=3 after 8 edges. Poll 3 cycles → reads 3 throughout; a following poll reads 0.
- **Bounce:** toggle `red_button` 1/0 every 2 cycles for 12 cycles, then hold high → exactly one event (code 1) is queued; `pressed[0]` rises once.
- **Simultaneous press:** raise all four buttons on the same edge → four polls return 1, 2, 3, 4, then 0.
- **Overflow:** enqueue 5 presses (red, blue, red, blue, green) without polling → polls return 0x101, 2, 1, 2, then 0 (green dropped; overflow cleared by the first pop).
- **Long poll / push during pop:** hold `poll` for 10 cycles while a yellow event enters the queue → exactly one pop. The next poll returns 4.
- **Reset mid-operation:** queue 2 events, assert `reset` low for 1 cycle with `blue_button` held → `button_out`=0 immediately. After release, one poll returns 2 and the next returns 0.
